// File: rtl/io_bus_controller_v2.sv
// CPU-bus to I/O-slot bridge: address decode, ack/wait handshake, timeout bus error,
// absent-slot tie-off and an internal IRQ/status register bank in the top slot.
//
// state  | meaning
// IDLE   | waiting for a bus request
// STROBE | one-cycle rd/wr strobe to the selected slot
// WAIT   | cs held, waiting for slot ack or timeout
// RESP   | bus_ready pulse, bus_err valid
module io_bus_controller_v2 #(
    parameter int                 N_SLOTS        = 16,
    parameter int                 REG_AW         = 5,
    parameter int                 TIMEOUT_CYCLES = 64,
    parameter logic [N_SLOTS-1:0] SLOT_PRESENT   = 16'h0007
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_cs,
    input  logic                  bus_wr,
    input  logic                  bus_rd,
    input  logic [31:0]           bus_addr,
    input  logic [31:0]           bus_wr_data,
    output logic [31:0]           bus_rd_data,
    output logic                  bus_ready,
    output logic                  bus_err,
    output logic [N_SLOTS-1:0]    slot_cs_array,
    output logic [N_SLOTS-1:0]    slot_mem_rd_array,
    output logic [N_SLOTS-1:0]    slot_mem_wr_array,
    output logic [REG_AW-1:0]     slot_reg_addr,
    output logic [31:0]           slot_wr_data,
    input  logic [N_SLOTS*32-1:0] slot_rd_data_array,
    input  logic [N_SLOTS-1:0]    slot_ack_array,
    input  logic [N_SLOTS-1:0]    slot_irq_array,
    output logic                  irq
);

    localparam int SW = $clog2(N_SLOTS);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0]      INT_SLOT    = SW'(N_SLOTS - 1);
    localparam logic [N_SLOTS-1:0] INT_BIT     = {1'b1, {(N_SLOTS-1){1'b0}}};
    localparam logic [N_SLOTS-1:0] EXT_PRESENT = SLOT_PRESENT & ~INT_BIT;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [REG_AW-1:0]   reg_q, reg_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic [CW-1:0]       tmr_q, tmr_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [SW-1:0]       err_slot_q, err_slot_d;
    logic [N_SLOTS-1:0]  pending_q, pending_d;
    logic [N_SLOTS-1:0]  mask_q, mask_d;
    logic [N_SLOTS-1:0]  irq_prev_q;
    logic                irq_q, irq_d;

    logic [SW-1:0]       req_slot;
    logic [REG_AW-1:0]   req_reg;
    logic                slot_ext, slot_int;
    logic [31:0]         sel_rd_data, int_rd_data, cap_data;
    logic [N_SLOTS-1:0]  sel_onehot, irq_rise, w1c;
    logic                err_event;
    logic [SW-1:0]       err_slot_new;

    assign req_slot    = bus_addr[REG_AW+2 +: SW];
    assign req_reg     = bus_addr[REG_AW+1:2];
    assign slot_ext    = EXT_PRESENT[slot_q];
    assign slot_int    = (slot_q == INT_SLOT);
    assign sel_rd_data = slot_rd_data_array[int'(slot_q)*32 +: 32];
    assign sel_onehot  = slot_ext ? (N_SLOTS'(1) << slot_q) : '0;

    always_comb begin
        int_rd_data = '0;
        case (reg_q)
            REG_AW'(0): int_rd_data = 32'(pending_q);
            REG_AW'(1): int_rd_data = 32'(mask_q);
            REG_AW'(2): int_rd_data = {19'd0, 5'(err_slot_q), err_cnt_q};
            default:    int_rd_data = '0;
        endcase
    end

    // Absent slots read as zero; the internal bank answers from its own registers.
    assign cap_data = slot_int ? int_rd_data : (slot_ext ? sel_rd_data : 32'd0);

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        err_d        = err_q;
        rd_data_d    = rd_data_q;
        tmr_d        = tmr_q;
        err_event    = 1'b0;
        err_slot_new = slot_q;
        case (state_q)
            IDLE: begin
                if (bus_cs && bus_rd && bus_wr) begin
                    state_d      = RESP;
                    err_d        = 1'b1;
                    rd_data_d    = '0;
                    err_event    = 1'b1;
                    err_slot_new = req_slot;
                end else if (bus_cs && (bus_rd || bus_wr)) begin
                    state_d = STROBE;
                    slot_d  = req_slot;
                    reg_d   = req_reg;
                    wdata_d = bus_wr_data;
                    wr_d    = bus_wr;
                    err_d   = 1'b0;
                end
            end
            STROBE: begin
                if (!slot_ext || slot_ack_array[slot_q]) begin
                    state_d = RESP;
                    if (!wr_q) rd_data_d = cap_data;
                end else begin
                    state_d = WAIT;
                    tmr_d   = CW'(TIMEOUT_CYCLES - 1);
                end
            end
            WAIT: begin
                if (slot_ack_array[slot_q]) begin
                    state_d = RESP;
                    if (!wr_q) rd_data_d = sel_rd_data;
                end else if (tmr_q == '0) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    err_event = 1'b1;
                    if (!wr_q) rd_data_d = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_slot_d = err_slot_q;
        if (err_event) begin
            err_slot_d = err_slot_new;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // A new rising edge overrides a same-cycle write-1-to-clear.
    always_comb begin
        irq_rise = slot_irq_array & ~irq_prev_q;
        w1c      = '0;
        mask_d   = mask_q;
        if (state_q == STROBE && slot_int && wr_q) begin
            if (reg_q == REG_AW'(0)) w1c    = wdata_q[N_SLOTS-1:0];
            if (reg_q == REG_AW'(1)) mask_d = wdata_q[N_SLOTS-1:0];
        end
        pending_d = (pending_q & ~w1c) | irq_rise;
        irq_d     = |(pending_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            tmr_q      <= '0;
            err_cnt_q  <= '0;
            err_slot_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            irq_prev_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            tmr_q      <= tmr_d;
            err_cnt_q  <= err_cnt_d;
            err_slot_q <= err_slot_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            irq_prev_q <= slot_irq_array;
            irq_q      <= irq_d;
        end
    end

    assign bus_ready         = (state_q == RESP);
    assign bus_err           = (state_q == RESP) && err_q;
    assign bus_rd_data       = rd_data_q;
    assign slot_cs_array     = (state_q == STROBE || state_q == WAIT) ? sel_onehot : '0;
    assign slot_mem_rd_array = (state_q == STROBE && !wr_q) ? sel_onehot : '0;
    assign slot_mem_wr_array = (state_q == STROBE && wr_q) ? sel_onehot : '0;
    assign slot_reg_addr     = reg_q;
    assign slot_wr_data      = wdata_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_io_bus_controller_v2.sv
// Directed bench for io_bus_controller_v2: slot accesses, wait/timeout, absent slots,
// internal IRQ/status bank and reset in mid-transaction.
module tb_io_bus_controller_v2;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_cs, bus_wr, bus_rd;
    logic [31:0]   bus_addr, bus_wr_data, bus_rd_data;
    logic          bus_ready, bus_err;
    logic [N-1:0]  slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
    logic [4:0]    slot_reg_addr;
    logic [31:0]   slot_wr_data;
    logic [N*32-1:0] slot_rd_data_array;
    logic [N-1:0]  slot_ack_array, slot_irq_array;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    int          x_lat, x_rd_stb, x_wr_stb, x_cs;
    logic [31:0] x_rdata;
    logic        x_err;
    logic [4:0]  x_stb_reg;
    logic [31:0] x_stb_data;
    logic [N-1:0] x_stb_wr, x_stb_rd;
    int          ready_seen;

    io_bus_controller_v2 dut (
        .clk                (clk),
        .reset              (reset),
        .bus_cs             (bus_cs),
        .bus_wr             (bus_wr),
        .bus_rd             (bus_rd),
        .bus_addr           (bus_addr),
        .bus_wr_data        (bus_wr_data),
        .bus_rd_data        (bus_rd_data),
        .bus_ready          (bus_ready),
        .bus_err            (bus_err),
        .slot_cs_array      (slot_cs_array),
        .slot_mem_rd_array  (slot_mem_rd_array),
        .slot_mem_wr_array  (slot_mem_wr_array),
        .slot_reg_addr      (slot_reg_addr),
        .slot_wr_data       (slot_wr_data),
        .slot_rd_data_array (slot_rd_data_array),
        .slot_ack_array     (slot_ack_array),
        .slot_irq_array     (slot_irq_array),
        .irq                (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one bus access; ack_dly = cycles after STROBE before the slot acks (-1: never).
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic rd, input logic wr, input int ack_slot,
                            input int ack_dly, input logic [31:0] ack_data, input int irq_c);
        int  c;
        logic done;
        x_lat = 0; x_rd_stb = 0; x_wr_stb = 0; x_cs = 0;
        x_rdata = 'x; x_err = 1'bx;
        slot_rd_data_array = '0;
        if (ack_slot >= 0) slot_rd_data_array[ack_slot*32 +: 32] = ack_data;
        bus_cs = 1'b1; bus_rd = rd; bus_wr = wr;
        bus_addr = addr; bus_wr_data = wdata;
        c = 0; done = 1'b0;
        while (!done && c < 200) begin
            @(posedge clk); #1;
            c++;
            slot_ack_array = '0;
            if (ack_slot >= 0 && ack_dly >= 0 && c == 1 + ack_dly) slot_ack_array[ack_slot] = 1'b1;
            if (c == irq_c) slot_irq_array[1] = 1'b1;
            if (c == 1) begin
                x_stb_reg  = slot_reg_addr;
                x_stb_data = slot_wr_data;
                x_stb_rd   = slot_mem_rd_array;
                x_stb_wr   = slot_mem_wr_array;
            end
            x_rd_stb += $countones(slot_mem_rd_array);
            x_wr_stb += $countones(slot_mem_wr_array);
            x_cs     += (slot_cs_array != '0) ? 1 : 0;
            if (bus_ready) begin
                done = 1'b1; x_lat = c; x_rdata = bus_rd_data; x_err = bus_err;
            end
        end
        check_val("xfer_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        slot_ack_array = '0;
        check_val("ready_pulse", 32'(bus_ready), 32'd0);
        bus_cs = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_cs = 0; bus_wr = 0; bus_rd = 0; bus_addr = '0; bus_wr_data = '0;
        slot_rd_data_array = '0; slot_ack_array = '0; slot_irq_array = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready",  32'(bus_ready), 32'd0);
        check_val("rst_err",    32'(bus_err), 32'd0);
        check_val("rst_rdata",  bus_rd_data, 32'd0);
        check_val("rst_cs",     32'(slot_cs_array), 32'd0);
        check_val("rst_irq",    32'(irq), 32'd0);
        check_val("rst_regadr", 32'(slot_reg_addr), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // write slot 0 reg 3, zero-wait
        bus_xfer(32'h0000_000C, 32'hA5A5_0001, 1'b0, 1'b1, 0, 0, 32'h0, 0);
        check_val("w0_lat",    32'(x_lat), 32'd2);
        check_val("w0_err",    32'(x_err), 32'd0);
        check_val("w0_wrstb",  32'(x_stb_wr), 32'h0001);
        check_val("w0_nwr",    32'(x_wr_stb), 32'd1);
        check_val("w0_nrd",    32'(x_rd_stb), 32'd0);
        check_val("w0_reg",    32'(x_stb_reg), 32'd3);
        check_val("w0_data",   x_stb_data, 32'hA5A5_0001);

        // read slot 1 reg 0, ack 5 cycles late
        bus_xfer(32'h0000_0080, 32'h0, 1'b1, 1'b0, 1, 5, 32'h1234_5678, 0);
        check_val("r1_lat",    32'(x_lat), 32'd7);
        check_val("r1_data",   x_rdata, 32'h1234_5678);
        check_val("r1_err",    32'(x_err), 32'd0);
        check_val("r1_rdstb",  32'(x_stb_rd), 32'h0002);
        check_val("r1_nrd",    32'(x_rd_stb), 32'd1);
        check_val("r1_cs",     32'(x_cs), 32'd6);

        // a write leaves the last read data in place
        bus_xfer(32'h0000_0004, 32'h0000_0055, 1'b0, 1'b1, 0, 1, 32'h0, 0);
        check_val("hold_lat",  32'(x_lat), 32'd3);
        check_val("hold_rd",   bus_rd_data, 32'h1234_5678);

        // read slot 2 with no ack: timeout
        bus_xfer(32'h0000_0100, 32'h0, 1'b1, 1'b0, -1, -1, 32'h0, 0);
        check_val("to_lat",    32'(x_lat), 32'd66);
        check_val("to_err",    32'(x_err), 32'd1);
        check_val("to_data",   x_rdata, 32'd0);
        check_val("to_ncs",    32'(x_cs), 32'd65);

        bus_xfer(32'h0000_0788, 32'h0, 1'b1, 1'b0, -1, -1, 32'h0, 0);
        check_val("st1_data",  x_rdata, 32'h0000_0201);
        check_val("st1_lat",   32'(x_lat), 32'd2);
        check_val("st1_ncs",   32'(x_cs), 32'd0);

        // absent slot 5: its stray ack and data must be ignored
        bus_xfer(32'h0000_0280, 32'h0, 1'b1, 1'b0, 5, 0, 32'hDEAD_BEEF, 0);
        check_val("ab_lat",    32'(x_lat), 32'd2);
        check_val("ab_data",   x_rdata, 32'd0);
        check_val("ab_err",    32'(x_err), 32'd0);
        check_val("ab_ncs",    32'(x_cs + x_rd_stb), 32'd0);

        // rd and wr together on slot 6
        bus_xfer(32'h0000_0300, 32'h1, 1'b1, 1'b1, -1, -1, 32'h0, 0);
        check_val("rw_lat",    32'(x_lat), 32'd1);
        check_val("rw_err",    32'(x_err), 32'd1);
        check_val("rw_nstb",   32'(x_rd_stb + x_wr_stb + x_cs), 32'd0);

        bus_xfer(32'h0000_0788, 32'h0, 1'b1, 1'b0, -1, -1, 32'h0, 0);
        check_val("st2_data",  x_rdata, 32'h0000_0602);

        // interrupts
        bus_xfer(32'h0000_0784, 32'h3, 1'b0, 1'b1, -1, -1, 32'h0, 0);
        bus_xfer(32'h0000_0784, 32'h0, 1'b1, 1'b0, -1, -1, 32'h0, 0);
        check_val("mask_rd",   x_rdata, 32'h3);
        slot_irq_array[1] = 1'b1;
        @(posedge clk); #1;
        check_val("irq_early", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check_val("irq_set",   32'(irq), 32'd1);
        slot_irq_array[1] = 1'b0;
        bus_xfer(32'h0000_0780, 32'h0, 1'b1, 1'b0, -1, -1, 32'h0, 0);
        check_val("pend_rd1",  x_rdata, 32'h2);

        bus_xfer(32'h0000_0780, 32'h2, 1'b0, 1'b1, -1, -1, 32'h0, 1);
        slot_irq_array[1] = 1'b0;
        bus_xfer(32'h0000_0780, 32'h0, 1'b1, 1'b0, -1, -1, 32'h0, 0);
        check_val("pend_setw", x_rdata, 32'h2);
        check_val("irq_hold",  32'(irq), 32'd1);

        bus_xfer(32'h0000_0780, 32'h2, 1'b0, 1'b1, -1, -1, 32'h0, 0);
        bus_xfer(32'h0000_0780, 32'h0, 1'b1, 1'b0, -1, -1, 32'h0, 0);
        check_val("pend_clr",  x_rdata, 32'h0);
        check_val("irq_clr",   32'(irq), 32'd0);

        // reset while waiting on slot 0
        slot_rd_data_array = '0; slot_ack_array = '0;
        bus_cs = 1'b1; bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = 32'h0;
        @(posedge clk); #1;
        check_val("rw_strobe", 32'(slot_mem_rd_array), 32'h0001);
        @(posedge clk); #1;
        check_val("rw_waitcs", 32'(slot_cs_array), 32'h0001);
        check_val("rw_waitrd", 32'(slot_mem_rd_array), 32'h0000);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rs_cs",     32'(slot_cs_array), 32'd0);
        check_val("rs_ready",  32'(bus_ready), 32'd0);
        reset = 1'b0; bus_cs = 1'b0; bus_rd = 1'b0;
        ready_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            ready_seen += bus_ready ? 1 : 0;
        end
        check_val("rs_noready", 32'(ready_seen), 32'd0);

        bus_xfer(32'h0000_0788, 32'h0, 1'b1, 1'b0, -1, -1, 32'h0, 0);
        check_val("rs_status", x_rdata, 32'h0);
        bus_xfer(32'h0000_0000, 32'h0, 1'b1, 1'b0, 0, 1, 32'hCAFE_F00D, 0);
        check_val("rs_lat",    32'(x_lat), 32'd3);
        check_val("rs_data",   x_rdata, 32'hCAFE_F00D);
        check_val("rs_err",    32'(x_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_bus_controller_v2.md
Name: io_bus_controller_v2

Overview:
- Parametrised successor to the fixed 16-slot I/O controller. Decodes CPU bus accesses onto N_SLOTS peripheral slots (UART, matrix multiplier, CORDIC, ...).
- Adds a wait-state handshake (per-slot ack), a timeout with bus error, tie-off handling for absent slots, and an interrupt aggregator.
- The highest slot index is the controller's own register bank: IRQ_PENDING, IRQ_MASK, STATUS.
- Sits between the core bus interface and the I/O slots, inside the I/O top level.

Parameters:
- N_SLOTS, 16, number of slots including the internal bank at index N_SLOTS-1; power of two, 4..32.
- REG_AW, 5, slot register word-address width.
- TIMEOUT_CYCLES, 64, WAIT cycles without ack before a bus error; >=2.
- SLOT_PRESENT, 16'h0007, bit i=1 means slot i is populated; the bit for N_SLOTS-1 is ignored (always internal).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- bus_cs  in  1  bus select
- bus_wr  in  1  write request
- bus_rd  in  1  read request
- bus_addr  in  32  byte address
- bus_wr_data  in  32  write data
- bus_rd_data  out  32  read data, valid while bus_ready=1
- bus_ready  out  1  one-cycle completion pulse
- bus_err  out  1  error flag, valid with bus_ready
- slot_cs_array  out  N_SLOTS  one-hot slot select
- slot_mem_rd_array  out  N_SLOTS  read strobe
- slot_mem_wr_array  out  N_SLOTS  write strobe
- slot_reg_addr  out  REG_AW  shared register address
- slot_wr_data  out  32  shared write data
- slot_rd_data_array  in  N_SLOTS*32  flattened; slot i at bits [32i+31:32i]
- slot_ack_array  in  N_SLOTS  slot completion
- slot_irq_array  in  N_SLOTS  level interrupt requests
- irq  out  1  aggregated interrupt, registered

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, IRQ_PENDING=0, IRQ_MASK=0, STATUS=0.
- Address decode:
  - reg = bus_addr[REG_AW+1:2]
  - slot = bus_addr[REG_AW+2 +: log2(N_SLOTS)]
  - Higher address bits are ignored.
- Request = bus_cs & (bus_rd | bus_wr). The master holds the request stable until bus_ready, then drops it the following cycle.
- FSM states: IDLE, STROBE, WAIT, RESP.
  - IDLE, request sampled: latch slot, reg, data and direction; go to STROBE.
  - IDLE, bus_rd & bus_wr both set: go to RESP with err=1, no strobe.
  - STROBE: assert slot_cs[slot] plus mem_rd or mem_wr for exactly one cycle; reg_addr and wr_data are held from STROBE through RESP. If ack is seen this cycle go to RESP, else go to WAIT.
  - WAIT: cs held high, rd/wr strobes low, counter increments. On ack go to RESP. If the counter reaches TIMEOUT_CYCLES-1 without ack, go to RESP with err=1.
  - RESP: bus_ready=1 for one cycle, bus_err as determined, then return to IDLE.
- Read data is captured from the selected slot on the ack cycle. It is held on bus_rd_data until the next read completes. Timeout or error reads return 0.
- Absent slots (SLOT_PRESENT bit = 0): no strobes; internal ack in STROBE; reads return 0; writes dropped; no error.
- Internal bank (slot N_SLOTS-1): acks internally in STROBE, no external strobes.
  - reg 0 IRQ_PENDING: read; write-1-to-clear.
  - reg 1 IRQ_MASK: read/write.
  - reg 2 STATUS: [7:0] saturating error count; [12:8] slot index of the last error.
  - Other regs: read 0, write ignored.
- Latency: a zero-wait access sampled at edge k gives STROBE in cycle k+1 and bus_ready in cycle k+2. A timed-out access gives bus_ready at cycle k+2+TIMEOUT_CYCLES.
- Errors (timeout or rd&wr): increment the error count, saturating at 255, and record the slot index.
- Interrupts:
  - pending[i] sets on a rising edge of slot_irq_array[i], detected against a registered copy.
  - A W1C and a set in the same cycle: set wins.
  - irq <= |(IRQ_PENDING & IRQ_MASK), one cycle after the pending/mask update.
- Acks arriving outside STROBE/WAIT, or from an unselected slot, are ignored.
- Reset mid-transaction: next state IDLE, strobes and bus_ready low the following cycle, the transaction is abandoned with no bus_ready.

Test Plan:
- Write 0xA5A5_0001 to slot 0 reg 3 (addr 0x0000_000C), slot acks in STROBE -> one-cycle mem_wr[0] with slot_reg_addr=3 and the data; bus_ready 2 cycles after the request; bus_err=0.
- Read slot 1 reg 0, ack delayed 5 cycles returning 0x1234_5678 -> single rd strobe, cs held through WAIT, bus_rd_data=0x1234_5678 with bus_ready, err=0.
- Read slot 2, ack never arrives (TIMEOUT_CYCLES=64) -> bus_ready with bus_err=1 at cycle k+66, rd_data=0, STATUS=0x0000_0201.
- Read absent slot 5 -> no strobes, bus_ready at k+2, data 0, err=0; write with bus_rd=bus_wr=1 -> err=1, no strobe.
- Write IRQ_MASK=0x3, pulse slot_irq[1] -> pending bit1 set, irq high one cycle later; W1C 0x2 in the same cycle as a new rising edge on slot_irq[1] -> bit stays 1.
- Assert reset during WAIT -> IDLE next cycle, cs deasserted, no bus_ready; the next read of slot 0 completes normally.
